// File: rtl/arch_rename_table.sv
// Architectural register file with rename tags/busy bits, same-cycle rename and commit bypass,
// and a circular FIFO of tag/busy checkpoints that can be popped or restored on branch resolution.
module arch_rename_table #(
   parameter int NUM_ARCH = 32,
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 6,
   parameter int RN_W     = 2,
   parameter int CM_W     = 2,
   parameter int NUM_CKPT = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      flush,
   input  logic [2*RN_W-1:0][$clog2(NUM_ARCH)-1:0]   rs_addr,
   output logic [2*RN_W-1:0][DATA_W-1:0]             rs_data,
   output logic [2*RN_W-1:0][TAG_W-1:0]              rs_tag,
   output logic [2*RN_W-1:0]                         rs_busy,
   input  logic [RN_W-1:0]                           rn_we,
   input  logic [RN_W-1:0][$clog2(NUM_ARCH)-1:0]     rn_addr,
   input  logic [RN_W-1:0][TAG_W-1:0]                rn_tag,
   input  logic [CM_W-1:0]                           cm_we,
   input  logic [CM_W-1:0][$clog2(NUM_ARCH)-1:0]     cm_addr,
   input  logic [CM_W-1:0][TAG_W-1:0]                cm_tag,
   input  logic [CM_W-1:0][DATA_W-1:0]               cm_data,
   input  logic                                      ck_alloc,
   output logic                                      ck_full,
   output logic                                      ck_empty,
   input  logic                                      br_valid,
   input  logic                                      br_mispred
);
   localparam int PW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
   localparam int CW = $clog2(NUM_CKPT + 1);

   typedef logic [NUM_ARCH-1:0][TAG_W-1:0] tag_vec_t;

   logic [NUM_ARCH-1:0][DATA_W-1:0] data_q, data_d;
   tag_vec_t                        tag_q, tag_d;
   logic [NUM_ARCH-1:0]             busy_q, busy_d;
   tag_vec_t                        ck_tag_q [NUM_CKPT];
   tag_vec_t                        ck_tag_d [NUM_CKPT];
   logic [NUM_ARCH-1:0]             ck_busy_q [NUM_CKPT];
   logic [NUM_ARCH-1:0]             ck_busy_d [NUM_CKPT];
   logic [PW-1:0]                   head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic                            restore, resolve, push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NUM_CKPT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign ck_full  = (cnt_q == CW'(NUM_CKPT));
   assign ck_empty = (cnt_q == '0);
   assign restore  = br_valid && br_mispred && !ck_empty;
   assign resolve  = br_valid && !br_mispred && !ck_empty;
   assign push     = ck_alloc && !ck_full && !restore;

   // Operand read: older-slot rename in the same bundle beats a same-cycle commit bypass.
   always_comb begin
      rs_data = '0;
      rs_tag  = '0;
      rs_busy = '0;
      for (int s = 0; s < 2*RN_W; s++) begin
         if (rs_addr[s] != '0) begin
            rs_data[s] = data_q[rs_addr[s]];
            rs_tag[s]  = tag_q[rs_addr[s]];
            rs_busy[s] = busy_q[rs_addr[s]];
            if (busy_q[rs_addr[s]]) begin
               for (int p = 0; p < CM_W; p++) begin
                  if (cm_we[p] && cm_addr[p] == rs_addr[s] && cm_tag[p] == tag_q[rs_addr[s]]) begin
                     rs_busy[s] = 1'b0;
                     rs_data[s] = cm_data[p];
                  end
               end
            end
            for (int i = 0; i < s/2; i++) begin
               if (rn_we[i] && rn_addr[i] == rs_addr[s]) begin
                  rs_busy[s] = 1'b1;
                  rs_tag[s]  = rn_tag[i];
                  rs_data[s] = data_q[rs_addr[s]];
               end
            end
         end
      end
   end

   always_comb begin
      data_d    = data_q;
      tag_d     = tag_q;
      busy_d    = busy_q;
      ck_tag_d  = ck_tag_q;
      ck_busy_d = ck_busy_q;
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      if (flush) begin
         busy_d = '0;
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         for (int p = 0; p < CM_W; p++) begin
            if (cm_we[p] && cm_addr[p] != '0) data_d[cm_addr[p]] = cm_data[p];
         end
         if (restore) begin
            tag_d  = ck_tag_q[head_q];
            busy_d = ck_busy_q[head_q];
         end
         // Commits retire against the pre-rename view (restored or current), then renames override.
         for (int p = 0; p < CM_W; p++) begin
            if (cm_we[p] && cm_addr[p] != '0 && busy_d[cm_addr[p]] && tag_d[cm_addr[p]] == cm_tag[p])
               busy_d[cm_addr[p]] = 1'b0;
         end
         if (!restore) begin
            for (int i = 0; i < RN_W; i++) begin
               if (rn_we[i] && rn_addr[i] != '0) begin
                  tag_d[rn_addr[i]]  = rn_tag[i];
                  busy_d[rn_addr[i]] = 1'b1;
               end
            end
         end
         // Clearing stale entries too is harmless: they are fully overwritten on push.
         for (int k = 0; k < NUM_CKPT; k++) begin
            for (int p = 0; p < CM_W; p++) begin
               if (cm_we[p] && cm_addr[p] != '0 && ck_busy_q[k][cm_addr[p]] &&
                   ck_tag_q[k][cm_addr[p]] == cm_tag[p])
                  ck_busy_d[k][cm_addr[p]] = 1'b0;
            end
         end
         if (restore) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
         end else begin
            if (resolve) head_d = ptr_inc(head_q);
            if (push) begin
               ck_tag_d[tail_q]  = tag_d;
               ck_busy_d[tail_q] = busy_d;
               tail_d            = ptr_inc(tail_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(resolve);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         tag_q  <= '0;
         busy_q <= '0;
         for (int k = 0; k < NUM_CKPT; k++) begin
            ck_tag_q[k]  <= '0;
            ck_busy_q[k] <= '0;
         end
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q    <= data_d;
         tag_q     <= tag_d;
         busy_q    <= busy_d;
         ck_tag_q  <= ck_tag_d;
         ck_busy_q <= ck_busy_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
      end
   end
endmodule
